// File: rtl/plic_master_pkg.sv
// Shared definitions for the hart-side PLIC claim/complete engine:
// FSM state encoding and claim/complete register address arithmetic.
package plic_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLAIM     = 3'd1,
    ST_DISPATCH  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4,
    ST_BACKOFF   = 3'd5
  } state_e;

  localparam logic [31:0] CC_OFFSET     = 32'h0020_0004;
  localparam logic [31:0] TARGET_STRIDE = 32'h0000_1000;

  function automatic logic [31:0] cc_addr(input logic [31:0] base, input logic [31:0] target);
    return base + CC_OFFSET + (target * TARGET_STRIDE);
  endfunction

endpackage

// File: rtl/reg_intf.sv
// Register-interface request/response types shared across the codebase.
// Requests carry addr/write/wdata/wstrb/valid; responses carry rdata/error/ready.
package reg_intf;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;

endpackage

// File: rtl/plic_claim_master.sv
// Claims an interrupt from the PLIC, hands the ID to a local consumer,
// completes it after service and backs off before sampling eip_i again.
module plic_claim_master
  import plic_master_pkg::*;
  import reg_intf::*;
#(
  parameter int unsigned N_SOURCE    = 30,
  parameter int unsigned SRCW        = $clog2(N_SOURCE + 1),
  parameter logic [31:0] PLIC_BASE   = 32'h0C00_0000,
  parameter int unsigned TARGET_ID   = 0,
  parameter int unsigned BACKOFF_CYC = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                eip_i,
  output reg_intf_req_a32_d32 req_o,
  input  reg_intf_resp_d32    resp_i,
  output logic                fence_o,
  output logic                irq_valid_o,
  output logic [SRCW-1:0]     irq_id_o,
  input  logic                irq_ready_i,
  input  logic                irq_done_i,
  output logic                busy_o,
  output logic                err_o,
  input  logic                clr_err_i
);

  localparam logic [31:0]     CC_ADDR  = cc_addr(PLIC_BASE, 32'(TARGET_ID));
  localparam int unsigned     CW       = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(BACKOFF_CYC - 1);
  localparam logic [SRCW-1:0] ID_MAX   = SRCW'(N_SOURCE);

  state_e              state_r, state_s;
  logic [SRCW-1:0]     id_r, id_s, rsp_id_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                err_set_s;
  reg_intf_req_a32_d32 req_r, req_s;
  logic                fence_r, fence_s;
  logic                irq_valid_r, irq_valid_s;
  logic [SRCW-1:0]     irq_id_r, irq_id_s;
  logic                busy_r, busy_s;
  logic                err_r, err_s;
  logic                rdata_unused_s;

  assign rsp_id_s       = resp_i.rdata[SRCW-1:0];
  assign rdata_unused_s = ^resp_i.rdata[31:SRCW];

  // Next-state, captured ID and backoff counter.
  always_comb begin
    state_s   = state_r;
    id_s      = id_r;
    cnt_s     = cnt_r;
    err_set_s = 1'b0;
    fence_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (eip_i) state_s = ST_CLAIM;
        else       state_s = ST_IDLE;
      end
      ST_CLAIM: begin
        if (resp_i.ready) begin
          id_s = rsp_id_s;
          if (resp_i.error) begin
            err_set_s = 1'b1;
            state_s   = ST_BACKOFF;
          end else if (rsp_id_s == '0) begin
            state_s = ST_BACKOFF;
          end else if (rsp_id_s > ID_MAX) begin
            err_set_s = 1'b1;
            state_s   = ST_BACKOFF;
          end else begin
            fence_s = 1'b1;
            state_s = ST_DISPATCH;
          end
        end else begin
          state_s = ST_CLAIM;
        end
      end
      ST_DISPATCH: begin
        if (irq_ready_i) state_s = irq_done_i ? ST_COMPLETE : ST_WAIT_DONE;
        else             state_s = ST_DISPATCH;
      end
      ST_WAIT_DONE: begin
        if (irq_done_i) state_s = ST_COMPLETE;
        else            state_s = ST_WAIT_DONE;
      end
      ST_COMPLETE: begin
        if (resp_i.ready) begin
          err_set_s = resp_i.error;
          state_s   = ST_BACKOFF;
        end else begin
          state_s = ST_COMPLETE;
        end
      end
      ST_BACKOFF: begin
        if (cnt_r == '0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r - 1'b1;
          state_s = ST_BACKOFF;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    // Every path into BACKOFF reloads the window.
    cnt_s = ((state_s == ST_BACKOFF) && (state_r != ST_BACKOFF)) ? CNT_LOAD : cnt_s;
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    req_s = '0;
    case (state_s)
      ST_CLAIM: begin
        req_s.valid = 1'b1;
        req_s.addr  = CC_ADDR;
      end
      ST_COMPLETE: begin
        req_s.valid = 1'b1;
        req_s.write = 1'b1;
        req_s.addr  = CC_ADDR;
        req_s.wdata = {{(32 - SRCW){1'b0}}, id_s};
        req_s.wstrb = 4'hF;
      end
      default: req_s = '0;
    endcase
    irq_valid_s = (state_s == ST_DISPATCH);
    irq_id_s    = irq_valid_s ? id_s : '0;
    busy_s      = (state_s != ST_IDLE);
    if (err_set_s)      err_s = 1'b1;
    else if (clr_err_i) err_s = 1'b0;
    else                err_s = err_r;
  end

  // State, ID, counter and all output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      id_r        <= '0;
      cnt_r       <= '0;
      req_r       <= '0;
      fence_r     <= 1'b0;
      irq_valid_r <= 1'b0;
      irq_id_r    <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      id_r        <= id_s;
      cnt_r       <= cnt_s;
      req_r       <= req_s;
      fence_r     <= fence_s;
      irq_valid_r <= irq_valid_s;
      irq_id_r    <= irq_id_s;
      busy_r      <= busy_s;
      err_r       <= err_s;
    end
  end

  assign req_o       = req_r;
  assign fence_o     = fence_r;
  assign irq_valid_o = irq_valid_r;
  assign irq_id_o    = irq_id_r;
  assign busy_o      = busy_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed bench for plic_claim_master (target 1): scoreboarded bus and
// consumer handshakes plus timing checks on fence, backoff, errors and reset.
module tb_plic_claim_master;
  import reg_intf::*;

  localparam int unsigned BACKOFF = 64;
  localparam logic [31:0] EXP_CC  = 32'h0C20_1004;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  logic                clk_i       = 1'b0;
  logic                rst_ni      = 1'b0;
  logic                eip_i       = 1'b0;
  logic                irq_ready_i = 1'b0;
  logic                irq_done_i  = 1'b0;
  logic                clr_err_i   = 1'b0;
  reg_intf_req_a32_d32 req_o;
  reg_intf_resp_d32    resp_i;
  logic                fence_o, irq_valid_o, busy_o, err_o;
  logic [4:0]          irq_id_o;

  int       n_cmp = 0;
  int       n_fail = 0;
  int       fence_cnt = 0;
  int       f0;
  logic     prev_fence = 1'b0;
  bus_exp_t exp_bus[$];
  logic [4:0] exp_id[$];
  bus_exp_t mon_e;
  logic [4:0] mon_id;

  always #5 clk_i = ~clk_i;

  plic_claim_master #(
    .N_SOURCE(30), .PLIC_BASE(32'h0C00_0000), .TARGET_ID(1), .BACKOFF_CYC(BACKOFF)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .eip_i(eip_i), .req_o(req_o), .resp_i(resp_i),
    .fence_o(fence_o), .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o),
    .irq_ready_i(irq_ready_i), .irq_done_i(irq_done_i), .busy_o(busy_o),
    .err_o(err_o), .clr_err_i(clr_err_i)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Bus scoreboard: each handshake must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (req_o.valid && resp_i.ready) begin
      n_cmp++;
      assert (exp_bus.size() != 0) else begin
        n_fail++;
        $error("FAIL bus_unexpected: write=%b addr=%0h wdata=%0h none expected", req_o.write, req_o.addr, req_o.wdata);
      end
      if (exp_bus.size() != 0) begin
        mon_e = exp_bus.pop_front();
        chk("bus_write", req_o.write, mon_e.write);
        chk("bus_addr",  req_o.addr,  mon_e.addr);
        chk("bus_wdata", req_o.wdata, mon_e.wdata);
        chk("bus_wstrb", req_o.wstrb, mon_e.wstrb);
      end
    end
  end

  // Consumer scoreboard and fence pulse shape.
  always @(negedge clk_i) begin
    if (irq_valid_o && irq_ready_i) begin
      n_cmp++;
      assert (exp_id.size() != 0) else begin
        n_fail++;
        $error("FAIL irq_unexpected: id=%0d none expected", irq_id_o);
      end
      if (exp_id.size() != 0) begin
        mon_id = exp_id.pop_front();
        chk("irq_id", irq_id_o, mon_id);
      end
    end
    if (fence_o) begin
      chk("fence_with_valid", irq_valid_o, 1'b1);
      chk("fence_width", prev_fence, 1'b0);
      fence_cnt <= fence_cnt + 1;
    end
    prev_fence <= fence_o;
  end

  task automatic bus_txn(input string tag, input int ws, input logic [31:0] rdata, input logic err);
    int n;
    reg_intf_req_a32_d32 snap;
    logic stable;
    n = 0;
    while (!req_o.valid && n < 100) begin step(); n++; end
    chk({tag, "_valid_seen"}, req_o.valid, 1'b1);
    snap = req_o;
    stable = 1'b1;
    for (int i = 0; i < ws; i++) begin
      step();
      if (req_o !== snap) stable = 1'b0;
    end
    chk({tag, "_req_stable"}, stable, 1'b1);
    resp_i.ready = 1'b1;
    resp_i.rdata = rdata;
    resp_i.error = err;
    step();
    resp_i = '0;
    chk({tag, "_valid_drop"}, req_o.valid, 1'b0);
  endtask

  task automatic consume(input string tag, input int ready_dly, input int done_dly, input logic done_with_ready);
    int n;
    logic [4:0] snap;
    logic stable;
    logic quiet;
    n = 0;
    while (!irq_valid_o && n < 100) begin step(); n++; end
    chk({tag, "_valid_seen"}, irq_valid_o, 1'b1);
    snap = irq_id_o;
    stable = 1'b1;
    for (int i = 0; i < ready_dly; i++) begin
      step();
      if (irq_id_o !== snap || !irq_valid_o) stable = 1'b0;
    end
    chk({tag, "_id_stable"}, stable, 1'b1);
    irq_ready_i = 1'b1;
    irq_done_i  = done_with_ready;
    step();
    irq_ready_i = 1'b0;
    irq_done_i  = 1'b0;
    chk({tag, "_valid_drop"}, irq_valid_o, 1'b0);
    if (!done_with_ready) begin
      quiet = 1'b1;
      for (int i = 0; i < done_dly; i++) begin
        step();
        if (req_o.valid) quiet = 1'b0;
      end
      chk({tag, "_no_early_complete"}, quiet, 1'b1);
      irq_done_i = 1'b1;
      step();
      irq_done_i = 1'b0;
      chk({tag, "_cmpl_req"}, {req_o.valid, req_o.write}, 2'b11);
    end
  endtask

  task automatic run_backoff(input string tag);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BACKOFF - 1; i++) begin
      step();
      if (req_o.valid || irq_valid_o || !busy_o) bad = 1'b1;
    end
    chk({tag, "_quiet"}, bad, 1'b0);
    step();
    chk({tag, "_busy_end"}, busy_o, 1'b0);
    chk({tag, "_valid_end"}, req_o.valid, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resp_i = '0;
    #3;
    chk("rst_req", req_o, 69'd0);
    chk("rst_fence", fence_o, 1'b0);
    chk("rst_irq_valid", irq_valid_o, 1'b0);
    chk("rst_irq_id", irq_id_o, 5'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    chk("idle_busy", busy_o, 1'b0);

    // Normal flow: one wait state, immediate accept, done 10 cycles later.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    exp_bus.push_back('{1'b1, EXP_CC, 32'd5, 4'hF});
    exp_id.push_back(5'd5);
    f0 = fence_cnt;
    eip_i = 1'b1;
    step();
    chk("n_claim_latency", req_o.valid, 1'b1);
    chk("n_claim_addr", req_o.addr, EXP_CC);
    bus_txn("n_claim", 1, 32'd5, 1'b0);
    eip_i = 1'b0;
    chk("n_fence", fence_o, 1'b1);
    chk("n_irq_id_now", irq_id_o, 5'd5);
    consume("n_irq", 0, 10, 1'b0);
    bus_txn("n_cmpl", 0, 32'd0, 1'b0);
    run_backoff("n_bo");
    chk("n_fence_count", fence_cnt - f0, 32'd1);

    // Spurious claim.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    f0 = fence_cnt;
    eip_i = 1'b1;
    bus_txn("s_claim", 0, 32'd0, 1'b0);
    eip_i = 1'b0;
    chk("s_no_valid", irq_valid_o, 1'b0);
    chk("s_no_fence", fence_o, 1'b0);
    chk("s_busy", busy_o, 1'b1);
    chk("s_err", err_o, 1'b0);
    run_backoff("s_bo");
    chk("s_fence_count", fence_cnt - f0, 32'd0);

    // Bus error on claim, then clear.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    eip_i = 1'b1;
    bus_txn("e_claim", 0, 32'd7, 1'b1);
    eip_i = 1'b0;
    chk("e_err_set", err_o, 1'b1);
    chk("e_no_dispatch", irq_valid_o, 1'b0);
    run_backoff("e_bo");
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    chk("e_err_clr", err_o, 1'b0);

    // ID above N_SOURCE.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    eip_i = 1'b1;
    bus_txn("r_claim", 0, 32'd31, 1'b0);
    eip_i = 1'b0;
    chk("r_err_set", err_o, 1'b1);
    chk("r_no_dispatch", irq_valid_o, 1'b0);
    run_backoff("r_bo");
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    chk("r_err_clr", err_o, 1'b0);

    // Error set while clear is held: set wins.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    eip_i = 1'b1;
    clr_err_i = 1'b1;
    bus_txn("c_claim", 0, 32'd0, 1'b1);
    chk("c_set_wins", err_o, 1'b1);
    clr_err_i = 1'b0;
    eip_i = 1'b0;
    run_backoff("c_bo");
    chk("c_err_sticky", err_o, 1'b1);
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;

    // Stalls: 3 wait states each access, ready low 4 cycles, done with ready.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    exp_bus.push_back('{1'b1, EXP_CC, 32'd9, 4'hF});
    exp_id.push_back(5'd9);
    eip_i = 1'b1;
    bus_txn("t_claim", 3, 32'd9, 1'b0);
    eip_i = 1'b0;
    consume("t_irq", 4, 0, 1'b1);
    chk("t_direct_complete", {req_o.valid, req_o.write}, 2'b11);
    chk("t_cmpl_wdata", req_o.wdata, 32'd9);
    bus_txn("t_cmpl", 3, 32'd0, 1'b0);
    run_backoff("t_bo");

    // Reset while waiting for done; no complete may follow.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    exp_id.push_back(5'd12);
    eip_i = 1'b1;
    bus_txn("w_claim", 0, 32'd12, 1'b0);
    eip_i = 1'b0;
    irq_ready_i = 1'b1;
    step();
    irq_ready_i = 1'b0;
    step();
    chk("w_in_wait_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("w_rst_req", req_o, 69'd0);
    chk("w_rst_irq_valid", irq_valid_o, 1'b0);
    chk("w_rst_irq_id", irq_id_o, 5'd0);
    chk("w_rst_busy", busy_o, 1'b0);
    step();
    rst_ni = 1'b1;
    irq_done_i = 1'b1;
    step();
    irq_done_i = 1'b0;
    step();
    chk("w_done_ignored", {busy_o, req_o.valid}, 2'b00);

    // Restart with a claim, keep eip high through backoff.
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    exp_bus.push_back('{1'b1, EXP_CC, 32'd3, 4'hF});
    exp_id.push_back(5'd3);
    eip_i = 1'b1;
    step();
    chk("w_restart_claim", {req_o.valid, req_o.write}, 2'b10);
    bus_txn("w2_claim", 2, 32'd3, 1'b0);
    consume("w2_irq", 0, 2, 1'b0);
    bus_txn("w2_cmpl", 0, 32'd0, 1'b0);
    run_backoff("w2_bo");
    step();
    chk("w2_reclaim_after_idle", {req_o.valid, req_o.write}, 2'b10);
    exp_bus.push_back('{1'b0, EXP_CC, 32'd0, 4'h0});
    bus_txn("w3_claim", 0, 32'd0, 1'b0);
    eip_i = 1'b0;
    run_backoff("w3_bo");

    repeat (3) step();
    chk("sb_bus_drained", exp_bus.size(), 32'd0);
    chk("sb_irq_drained", exp_id.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
